// File: rtl/instruction_fetch_unit_if.sv
// Wishbone instruction-bus interface: read-only master (fetch unit) and slave (memory) views.
interface wishbone_if;
  logic        cycle;
  logic        strobe;
  logic [3:0]  select;
  logic [31:0] address;
  logic        write_enable;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (
    output cycle, strobe, select, address, write_enable, data_in,
    input  data_out, ack
  );

  modport slave (
    input  cycle, strobe, select, address, write_enable, data_in,
    output data_out, ack
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Non-pipelined instruction fetch over a Wishbone master port with redirect handling.
// Optional misaligned-target fault and HALT state: define FETCH_ALIGN_CHECK_EN.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned RETIRE_GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  wishbone_if.master  wishbone_bus,
  input  logic        i_stall,
  input  logic        i_branch_valid,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_instruction_valid,
  output logic        o_fetch_fault
);

  localparam int unsigned GW = (RETIRE_GAP > 1) ? $clog2(RETIRE_GAP) : 1;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT_ACK,
    S_RETIRE
`ifdef FETCH_ALIGN_CHECK_EN
    , S_HALT
`endif
  } t_state;

  t_state      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_adr;
  logic        r_stb;
  logic        r_cyc;
  logic [31:0] r_instr;
  logic [31:0] r_out_pc;
  logic        r_valid;
  logic [GW-1:0] r_gap;
  logic        r_pend;
  logic [31:0] r_pend_target;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        r_fault;
`endif

  logic        w_redir;
  logic [31:0] w_redir_tgt;
  logic [31:0] w_redir_pc;
  logic        w_redir_bad;

  // A redirect is taken immediately outside WAIT_ACK, or at ack time inside it
  // (a same-cycle branch beats any stored pending target).
  always_comb begin
    w_redir     = 1'b0;
    w_redir_tgt = i_branch_target;
    case (r_state)
      S_FETCH, S_RETIRE: w_redir = i_branch_valid;
      S_WAIT_ACK: begin
        if (wishbone_bus.ack && (i_branch_valid || r_pend)) begin
          w_redir     = 1'b1;
          w_redir_tgt = i_branch_valid ? i_branch_target : r_pend_target;
        end
      end
      default: w_redir = 1'b0;
    endcase
  end

  assign w_redir_pc = w_redir_tgt & 32'hFFFF_FFFC;
`ifdef FETCH_ALIGN_CHECK_EN
  assign w_redir_bad = |w_redir_tgt[1:0];
`else
  assign w_redir_bad = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_adr         <= '0;
      r_stb         <= 1'b0;
      r_cyc         <= 1'b0;
      r_instr       <= '0;
      r_out_pc      <= '0;
      r_valid       <= 1'b0;
      r_gap         <= '0;
      r_pend        <= 1'b0;
      r_pend_target <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_fault       <= 1'b0;
`endif
    end else if (w_redir) begin
      r_stb   <= 1'b0;
      r_cyc   <= 1'b0;
      r_adr   <= '0;
      r_valid <= 1'b0;
      r_pend  <= 1'b0;
      if (w_redir_bad) begin
`ifdef FETCH_ALIGN_CHECK_EN
        r_fault <= 1'b1;
        r_state <= S_HALT;
`endif
      end else begin
        r_pc    <= w_redir_pc;
        r_state <= S_FETCH;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          r_stb   <= 1'b1;
          r_cyc   <= 1'b1;
          r_adr   <= r_pc;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (wishbone_bus.ack) begin
            r_stb    <= 1'b0;
            r_cyc    <= 1'b0;
            r_adr    <= '0;
            r_instr  <= wishbone_bus.data_out;
            r_out_pc <= r_pc;
            r_valid  <= 1'b1;
            r_gap    <= GW'(RETIRE_GAP - 1);
            r_state  <= S_RETIRE;
          end else if (i_branch_valid) begin
            r_pend        <= 1'b1;
            r_pend_target <= i_branch_target;
          end
        end
        S_RETIRE: begin
          r_valid <= 1'b0;
          if (r_gap != '0) begin
            r_gap <= r_gap - 1'b1;
          end else if (!i_stall) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign wishbone_bus.cycle        = r_cyc;
  assign wishbone_bus.strobe       = r_stb;
  assign wishbone_bus.address      = r_adr;
  assign wishbone_bus.select       = 4'b1111;
  assign wishbone_bus.write_enable = 1'b0;
  assign wishbone_bus.data_in      = '0;

  assign o_instruction       = r_instr;
  assign o_pc                = r_out_pc;
  assign o_instruction_valid = r_valid;
`ifdef FETCH_ALIGN_CHECK_EN
  assign o_fetch_fault       = r_fault;
`else
  assign o_fetch_fault       = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: bench-side memory model and expected-fetch scoreboard.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_stall = 1'b0;
  logic        i_branch_valid = 1'b0;
  logic [31:0] i_branch_target = '0;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        o_instruction_valid;
  logic        o_fetch_fault;

  wishbone_if bus();

  instruction_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .RETIRE_GAP (2)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .wishbone_bus        (bus),
    .i_stall             (i_stall),
    .i_branch_valid      (i_branch_valid),
    .i_branch_target     (i_branch_target),
    .o_instruction       (o_instruction),
    .o_pc                (o_pc),
    .o_instruction_valid (o_instruction_valid),
    .o_fetch_fault       (o_fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned req_cnt = 0;
  int unsigned valid_cnt = 0;
  int unsigned lat_cnt = 0;
  int unsigned mem_lat = 1;
  int unsigned last_req_cyc = 0;
  int unsigned last_valid_cyc = 0;
  int unsigned cset = 0;
  int unsigned snap_req = 0;
  int unsigned snap_valid = 0;
  logic [31:0] last_req_addr = '0;
  logic        prev_stb = 1'b0;
  logic        prev_valid = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0010_0113;
      32'h0000_0010: return 32'hDEAD_BEEF;
      default:       return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    sb.push_back(e);
  endtask

  // One clock: sample outputs 1 time unit after the edge, then advance the memory model.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (o_instruction_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc;
      chk("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_valid observed=pulse pc=%h expected=no pulse", o_pc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("valid_pc", o_pc, e.pc);
        chk("valid_instr", o_instruction, e.instr);
      end
    end
    prev_valid = o_instruction_valid;
    if (bus.strobe && !prev_stb) begin
      req_cnt++;
      last_req_addr = bus.address;
      last_req_cyc  = cyc;
    end
    prev_stb = bus.strobe;
    if (bus.ack) begin
      bus.ack = 1'b0;
      lat_cnt = 0;
    end else if (bus.strobe && bus.cycle) begin
      lat_cnt++;
      if (lat_cnt == mem_lat + 1) begin
        bus.ack      = 1'b1;
        bus.data_out = mem_word(bus.address);
      end
    end
  endtask

  task automatic wait_req(input logic [31:0] exp_addr, input string tag);
    int unsigned start;
    int unsigned n;
    start = req_cnt;
    n = 0;
    while (req_cnt == start && n < 60) begin
      tick();
      n++;
    end
    total++;
    assert (req_cnt != start) else begin
      bad++;
      $error("FAIL %s_timeout observed=no request expected=request", tag);
    end
    if (req_cnt != start) chk({tag, "_addr"}, last_req_addr, exp_addr);
  endtask

  task automatic wait_valid(input string tag);
    int unsigned start;
    int unsigned n;
    start = valid_cnt;
    n = 0;
    while (valid_cnt == start && n < 60) begin
      tick();
      n++;
    end
    total++;
    assert (valid_cnt != start) else begin
      bad++;
      $error("FAIL %s_timeout observed=no valid expected=valid", tag);
    end
  endtask

  initial begin
    int unsigned n;
    bus.ack      = 1'b0;
    bus.data_out = '0;

    // Reset state
    tick();
    tick();
    chk("rst_strobe", {31'd0, bus.strobe}, 32'd0);
    chk("rst_cycle", {31'd0, bus.cycle}, 32'd0);
    chk("rst_we", {31'd0, bus.write_enable}, 32'd0);
    chk("rst_select", {28'd0, bus.select}, 32'hF);
    chk("rst_address", bus.address, 32'd0);
    chk("rst_data_in", bus.data_in, 32'd0);
    chk("rst_instr", o_instruction, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_valid", {31'd0, o_instruction_valid}, 32'd0);
    chk("rst_fault", {31'd0, o_fetch_fault}, 32'd0);
    reset = 1'b0;

    // Sequential fetches and retire gap
    push_exp(32'h0);
    push_exp(32'h4);
    wait_req(32'h0, "req_pc0");
    chk("bus_select_active", {28'd0, bus.select}, 32'hF);
    chk("bus_we_active", {31'd0, bus.write_enable}, 32'd0);
    wait_valid("valid_pc0");
    wait_req(32'h4, "req_pc4");
    chk("retire_gap", last_req_cyc - last_valid_cyc, 32'd3);
    wait_valid("valid_pc4");

    // Stall hold
    push_exp(32'h8);
    wait_req(32'h8, "req_pc8");
    wait_valid("valid_pc8");
    i_stall = 1'b1;
    snap_req = req_cnt;
    repeat (10) tick();
    chk("stall_no_request", req_cnt, snap_req);
    i_stall = 1'b0;
    cset = cyc;
    push_exp(32'hC);
    wait_req(32'hC, "req_after_stall");
    chk("stall_release_latency", last_req_cyc - cset, 32'd2);
    wait_valid("valid_pc12");

    // Redirect while waiting for ack; latest target wins, returned data dropped
    mem_lat = 3;
    wait_req(32'h10, "req_pc16");
    i_branch_valid  = 1'b1;
    i_branch_target = 32'h180;
    tick();
    i_branch_target = 32'h100;
    tick();
    i_branch_valid = 1'b0;
    push_exp(32'h100);
    wait_req(32'h100, "req_pending_redirect");
    wait_valid("valid_pc100");

    // Redirect coincident with ack
    mem_lat = 1;
    wait_req(32'h104, "req_pc104");
    n = 0;
    while (!bus.ack && n < 10) begin
      tick();
      n++;
    end
    chk("ack_seen", {31'd0, bus.ack}, 32'd1);
    i_branch_valid  = 1'b1;
    i_branch_target = 32'h200;
    tick();
    i_branch_valid = 1'b0;
    push_exp(32'h200);
    wait_req(32'h200, "req_ack_redirect");
    wait_valid("valid_pc200");

    // Redirect during stalled RETIRE
    i_stall = 1'b1;
    repeat (3) tick();
    cset = cyc;
    i_branch_valid  = 1'b1;
    i_branch_target = 32'h240;
    tick();
    i_branch_valid = 1'b0;
    push_exp(32'h240);
    wait_req(32'h240, "req_retire_redirect");
    chk("retire_redirect_latency", last_req_cyc - cset, 32'd2);
    wait_valid("valid_pc240");
    i_stall = 1'b0;

    // PC wrap
    i_branch_valid  = 1'b1;
    i_branch_target = 32'hFFFF_FFFC;
    push_exp(32'hFFFF_FFFC);
    tick();
    i_branch_valid = 1'b0;
    wait_req(32'hFFFF_FFFC, "req_top");
    wait_valid("valid_top");
    mem_lat = 3;
    wait_req(32'h0, "req_wrap");

    // Asynchronous reset mid-transaction
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_strobe", {31'd0, bus.strobe}, 32'd0);
    chk("async_rst_cycle", {31'd0, bus.cycle}, 32'd0);
    chk("async_rst_address", bus.address, 32'd0);
    chk("async_rst_pc", o_pc, 32'd0);
    chk("async_rst_instr", o_instruction, 32'd0);
    bus.ack = 1'b0;
    lat_cnt = 0;
    tick();
    tick();
    reset = 1'b0;
    mem_lat = 1;
    push_exp(32'h0);
    wait_req(32'h0, "req_after_reset");
    wait_valid("valid_after_reset");

    // Misaligned redirect target
    i_branch_valid  = 1'b1;
    i_branch_target = 32'h102;
    tick();
    i_branch_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("fault_set", {31'd0, o_fetch_fault}, 32'd1);
    snap_req   = req_cnt;
    snap_valid = valid_cnt;
    repeat (20) tick();
    chk("halt_no_request", req_cnt, snap_req);
    chk("halt_no_valid", valid_cnt, snap_valid);
    chk("halt_strobe", {31'd0, bus.strobe}, 32'd0);
    chk("fault_sticky", {31'd0, o_fetch_fault}, 32'd1);
`else
    chk("no_fault", {31'd0, o_fetch_fault}, 32'd0);
    push_exp(32'h100);
    wait_req(32'h100, "req_aligned_target");
    wait_valid("valid_aligned_target");
    chk("no_fault_after", {31'd0, o_fetch_fault}, 32'd0);
`endif

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
